fp16multiplier: RTL and testbench
=================================

# fp16multiplier

Pipelined IEEE-754 binary16 multiplier that sits directly upstream of `fp16adder` in the vertex datapath. Each product it emits is one adder operand. It accepts one operand pair per cycle, produces the rounded product three cycles later, and tags every result with a valid bit. The datapath then knows which adder inputs carry real products.

## Interface
- Parameters: none. The format is fixed at binary16: 1 sign bit, 5 exponent bits with bias 15, 10 fraction bits.
- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset, sampled on the rising edge of `clk`.
- `in_valid` input 1: `a`/`b` hold a valid operand pair this cycle.
- `a` input 16: operand A, binary16.
- `b` input 16: operand B, binary16.
- `out` output 16: binary16 product, registered.
- `out_valid` output 1: `out` holds a new product this cycle.

## Operation
- Stage 1 (decode), registers:
  - sign = a[15]^b[15];
  - exponents and fractions;
  - class flags: zero, inf, nan.
  - Exponent field 0 (zero or subnormal) is classed as zero. Subnormal inputs are flushed to zero.
  - Normal operands get their hidden 1 prepended, giving 11-bit significands.
- Stage 2 (multiply), registers:
  - the 22-bit product of the significands;
  - the exponent sum ea+eb−15, computed as signed 8-bit;
  - the sign and the class flags.
- Stage 3 (normalise/round/pack), registers `out`:
  - If product[21]=1, shift right by 1 and add 1 to the exponent.
  - The kept fraction is 10 bits below the leading 1. Guard is the next bit; sticky is the OR of the remaining bits.
  - Rounding is round-to-nearest-even: increment when guard & (sticky | lsb).
  - A rounding carry out of the significand renormalises the result and adds 1 to the exponent.
- Special-case priority, highest first:
  1. Either input is NaN, or inf×zero: output 16'h7E00 (canonical quiet NaN, sign 0).
  2. Either input is inf: output {sign, 5'h1F, 10'h0}.
  3. Either input is zero: output {sign, 15'h0}.
  4. Final biased exponent ≥ 31: output {sign, 5'h1F, 10'h0}. Overflow goes to infinity.
  5. Final biased exponent ≤ 0: output {sign, 15'h0}. The result is flushed to zero, and the check is made after rounding.
  6. Otherwise: output {sign, exp[4:0], frac}.
- No backpressure: the block accepts one operand pair every cycle, and downstream always accepts.
- Each stage carries a valid bit, so stage valids and `out_valid` form a 3-deep shift of `in_valid`.
- When `in_valid`=0, `a` and `b` are don't-care and must not affect any later output.
- `out` loads only when the stage-3 valid is 1. Otherwise it holds its previous value.

## Timing
- Latency 3: a pair sampled with `in_valid`=1 at edge N appears on `out`, with `out_valid`=1, after edge N+3.
- Throughput: 1 result per cycle. Back-to-back valid inputs give back-to-back valid outputs in the same order.
- Bubbles: a gap in `in_valid` produces an identical gap in `out_valid` three cycles later.
- Reset values:
  - `out`=16'h0000 and `out_valid`=0;
  - every stage valid = 0;
  - all datapath registers = 0.
- Reset in the middle of operation discards every in-flight pair. `out_valid` stays 0 until three cycles after the first valid input sampled with `rst` low.
- If `rst` and `in_valid` are both high on the same edge, reset wins and the pair is dropped.

## Test plan
- Basic product and latency:
  - Stimulus: at edge 0, `a`=16'h4000 (2.0), `b`=16'h4200 (3.0), `in_valid`=1.
  - Required: `out`=16'h4600 with `out_valid`=1 exactly after edge 3, and `out_valid`=0 on all other cycles.
- Back-to-back stream:
  - Stimulus, one pair per cycle in this order: 4000×4200, C000×4200, 3E00×3E00, 3C01×3C01.
  - Required on consecutive cycles: 4600, C600, 4080, 3C02.
- Rounding tie:
  - Stimulus: 3C01×3E00.
  - Required: 16'h3E02, by round-to-nearest-even at the tie 513.5 → 514.
- Overflow and underflow:
  - 7BFF×4000 → 7C00.
  - 0400×3800 → 0000.
  - 8400×3800 → 8000.
  - Subnormal input 0001×7BFF → 0000.
- Specials:
  - 7C00×0000 → 7E00.
  - 7E00×3C00 → 7E00.
  - FC00×4000 → FC00.
  - 8000×4200 → 8000.
- Reset mid-operation and bubbles:
  - Stimulus: valid pairs at edges 0, 1 and 2, then `rst`=1 at edge 2 → no `out_valid` pulse follows.
  - Stimulus: `in_valid` pattern 1,0,1 → `out_valid` pattern 1,0,1 starting three cycles later, and `out` holds its value through the gap.

Source files
------------

// File: rtl/fp16multiplier.sv
// fp16multiplier: 3-stage pipelined IEEE-754 binary16 multiplier, round-to-nearest-even.
// Latency 3 edges (decode, multiply, normalise/round/pack); one operand pair per cycle.
// No backpressure: every cycle is accepted and downstream always accepts.
//
// Ports:
//   clk       - single clock, rising edge
//   rst       - synchronous active-high reset
//   in_valid  - a/b carry a valid operand pair this cycle
//   a, b      - binary16 operands
//   out       - registered binary16 product (holds when no new result)
//   out_valid - out carries a new product this cycle
//
// Subnormal inputs are flushed to zero, and results that round to a biased
// exponent <= 0 are also flushed to zero, so no denormal handling is needed.

module fp16multiplier (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] out,
  output logic        out_valid
);

  // ---------------------------------------------------------------
  // Stage 1: decode and classify
  // ---------------------------------------------------------------
  logic [4:0] w_ea;
  logic [4:0] w_eb;
  logic       w_a_zero;
  logic       w_b_zero;
  logic       w_a_inf;
  logic       w_b_inf;
  logic       w_a_nan;
  logic       w_b_nan;

  assign w_ea     = a[14:10];
  assign w_eb     = b[14:10];
  assign w_a_zero = (w_ea == 5'd0);
  assign w_b_zero = (w_eb == 5'd0);
  assign w_a_inf  = (w_ea == 5'h1F) && (a[9:0] == 10'd0);
  assign w_b_inf  = (w_eb == 5'h1F) && (b[9:0] == 10'd0);
  assign w_a_nan  = (w_ea == 5'h1F) && (a[9:0] != 10'd0);
  assign w_b_nan  = (w_eb == 5'h1F) && (b[9:0] != 10'd0);

  logic        r1_vld;
  logic        r1_sign;
  logic [4:0]  r1_ea;
  logic [4:0]  r1_eb;
  logic [10:0] r1_ma;
  logic [10:0] r1_mb;
  logic        r1_nan;
  logic        r1_inf;
  logic        r1_zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      r1_vld  <= 1'b0;
      r1_sign <= 1'b0;
      r1_ea   <= 5'd0;
      r1_eb   <= 5'd0;
      r1_ma   <= 11'd0;
      r1_mb   <= 11'd0;
      r1_nan  <= 1'b0;
      r1_inf  <= 1'b0;
      r1_zero <= 1'b0;
    end else begin
      r1_vld <= in_valid;
      // Datapath only loads on valid pairs so idle inputs never leak forward.
      if (in_valid) begin
        r1_sign <= a[15] ^ b[15];
        r1_ea   <= w_ea;
        r1_eb   <= w_eb;
        // Exponent field 0 (zero or subnormal) gets a zero significand.
        r1_ma   <= w_a_zero ? 11'd0 : {1'b1, a[9:0]};
        r1_mb   <= w_b_zero ? 11'd0 : {1'b1, b[9:0]};
        // inf x zero is folded into the NaN flag so later stages see one class.
        r1_nan  <= w_a_nan | w_b_nan | (w_a_inf & w_b_zero) | (w_a_zero & w_b_inf);
        r1_inf  <= w_a_inf | w_b_inf;
        r1_zero <= w_a_zero | w_b_zero;
      end
    end
  end

  // ---------------------------------------------------------------
  // Stage 2: significand multiply, exponent sum
  // ---------------------------------------------------------------
  logic               r2_vld;
  logic               r2_sign;
  logic [21:0]        r2_prod;
  logic signed [7:0]  r2_exp;
  logic               r2_nan;
  logic               r2_inf;
  logic               r2_zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      r2_vld  <= 1'b0;
      r2_sign <= 1'b0;
      r2_prod <= 22'd0;
      r2_exp  <= 8'sd0;
      r2_nan  <= 1'b0;
      r2_inf  <= 1'b0;
      r2_zero <= 1'b0;
    end else begin
      r2_vld <= r1_vld;
      if (r1_vld) begin
        r2_sign <= r1_sign;
        r2_prod <= {11'd0, r1_ma} * {11'd0, r1_mb};
        // Range is -13..45, comfortably inside signed 8 bits.
        r2_exp  <= $signed({3'b000, r1_ea}) + $signed({3'b000, r1_eb}) - 8'sd15;
        r2_nan  <= r1_nan;
        r2_inf  <= r1_inf;
        r2_zero <= r1_zero;
      end
    end
  end

  // ---------------------------------------------------------------
  // Stage 3: normalise, round, pack
  // ---------------------------------------------------------------
  logic              w_hi;
  logic [9:0]        w_frac_pre;
  logic              w_guard;
  logic              w_sticky;
  logic              w_round;
  logic [11:0]       w_sig_rnd;
  logic signed [7:0] w_exp_norm;
  logic signed [7:0] w_exp_fin;
  logic [15:0]       w_result;

  // Product of two 1.x significands lies in [1,4); bit 21 set means >= 2.
  assign w_hi       = r2_prod[21];
  assign w_frac_pre = w_hi ? r2_prod[20:11] : r2_prod[19:10];
  assign w_guard    = w_hi ? r2_prod[10]    : r2_prod[9];
  assign w_sticky   = w_hi ? (|r2_prod[9:0]) : (|r2_prod[8:0]);
  assign w_round    = w_guard & (w_sticky | w_frac_pre[0]);
  assign w_exp_norm = r2_exp + $signed({7'd0, w_hi});

  // A carry into bit 11 means the significand rounded up to 2.0; the low
  // 10 bits are then already zero, so only the exponent needs the bump.
  assign w_sig_rnd  = {2'b01, w_frac_pre} + {11'd0, w_round};
  assign w_exp_fin  = w_exp_norm + $signed({7'd0, w_sig_rnd[11]});

  always_comb begin
    w_result = {r2_sign, w_exp_fin[4:0], w_sig_rnd[9:0]};
    if (r2_nan) begin
      w_result = 16'h7E00;
    end else if (r2_inf) begin
      w_result = {r2_sign, 5'h1F, 10'h000};
    end else if (r2_zero) begin
      w_result = {r2_sign, 15'h0000};
    end else if (w_exp_fin >= 8'sd31) begin
      w_result = {r2_sign, 5'h1F, 10'h000};
    end else if (w_exp_fin <= 8'sd0) begin
      w_result = {r2_sign, 15'h0000};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= 16'h0000;
      out_valid <= 1'b0;
    end else begin
      out_valid <= r2_vld;
      if (r2_vld) begin
        out <= w_result;
      end
    end
  end

endmodule

// File: tb/tb_fp16multiplier.sv
// Testbench for fp16multiplier: directed spec vectors plus randomized pairs,
// expected results queued at issue time and checked by an independent monitor.
// Checks value, exact arrival cycle, bubbles, output hold and reset behaviour.

module tb_fp16multiplier;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] out;
  logic        out_valid;

  fp16multiplier dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out       (out),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   cyc = 0;
  logic rst_q;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  typedef struct {
    logic [15:0] val;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [15:0] last_out = 16'h0000;

  // Reference: exact integer product of the significands, rounded to 11
  // significant bits by comparing the discarded remainder with one half.
  function automatic logic [15:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
    int          ex;
    int          ey;
    int          fx;
    int          fy;
    int          e;
    int          sh;
    logic        s;
    logic        zx;
    logic        zy;
    logic        ix;
    logic        iy;
    logic        nx;
    logic        ny;
    longint      p;
    longint      q;
    longint      r;
    longint      half;
    logic [4:0]  ef;
    logic [9:0]  qf;
    ex = int'(x[14:10]);
    ey = int'(y[14:10]);
    fx = int'(x[9:0]);
    fy = int'(y[9:0]);
    s  = x[15] ^ y[15];
    zx = (ex == 0);
    zy = (ey == 0);
    ix = (ex == 31) && (fx == 0);
    iy = (ey == 31) && (fy == 0);
    nx = (ex == 31) && (fx != 0);
    ny = (ey == 31) && (fy != 0);
    if (nx || ny || (ix && zy) || (iy && zx)) return 16'h7E00;
    if (ix || iy) return {s, 5'h1F, 10'h000};
    if (zx || zy) return {s, 15'h0000};
    p  = longint'(1024 + fx) * longint'(1024 + fy);
    e  = ex + ey - 15;
    sh = (p >= (longint'(1) << 21)) ? 11 : 10;
    e  = e + sh - 10;
    q    = p >> sh;
    r    = p - (q << sh);
    half = longint'(1) << (sh - 1);
    if ((r > half) || ((r == half) && (q % 2 == 1))) q = q + 1;
    if (q == 2048) begin
      q = 1024;
      e = e + 1;
    end
    if (e >= 31) return {s, 5'h1F, 10'h000};
    if (e <= 0) return {s, 15'h0000};
    ef = e[4:0];
    qf = q[9:0];
    return {s, ef, qf};
  endfunction

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (cyc > 0) begin
      if (rst_q === 1'b1) begin
        n_cmp++;
        if (out_valid !== 1'b0 || out !== 16'h0000) begin
          n_fail++;
          $display("FAIL reset_state: out=%h out_valid=%b, required out=0000 out_valid=0",
                   out, out_valid);
        end
        sb.delete();
        last_out = 16'h0000;
      end else if (out_valid === 1'b1) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_valid: cycle %0d out=%h, no result expected", cyc, out);
        end else begin
          e = sb.pop_front();
          if (out !== e.val || cyc != e.due) begin
            n_fail++;
            $display("FAIL product: out=%h at cycle %0d, required %h at cycle %0d",
                     out, cyc, e.val, e.due);
          end
          last_out = e.val;
        end
      end else begin
        n_cmp++;
        if (out_valid !== 1'b0 || out !== last_out) begin
          n_fail++;
          $display("FAIL hold: cycle %0d out=%h out_valid=%b, required out=%h out_valid=0",
                   cyc, out, out_valid, last_out);
        end
        if (sb.size() > 0 && sb[0].due <= cyc) begin
          e = sb.pop_front();
          n_fail++;
          $display("FAIL missing_valid: cycle %0d no output, required %h at cycle %0d",
                   cyc, e.val, e.due);
        end
      end
    end
  end

  // Drive one cycle; for valid pairs queue the expected product.
  task automatic issue(input logic [15:0] ta, input logic [15:0] tb_v, input logic v,
                       input logic use_ref, input logic [15:0] want);
    exp_t e;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = v;
    a        = v ? ta : 16'($urandom);
    b        = v ? tb_v : 16'($urandom);
    if (v) begin
      e.val = use_ref ? ref_mul(ta, tb_v) : want;
      e.due = cyc + 3;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) issue(16'h0, 16'h0, 1'b0, 1'b0, 16'h0);
  endtask

  function automatic logic [15:0] rand_operand();
    logic [15:0] v;
    int          k;
    k = $urandom_range(0, 19);
    if (k == 0)      v = {1'($urandom), 5'h00, 10'($urandom)};
    else if (k == 1) v = {1'($urandom), 5'h1F, 10'h000};
    else if (k == 2) v = {1'($urandom), 5'h1F, 10'($urandom_range(1, 1023))};
    else if (k < 6)  v = 16'($urandom);
    else             v = {1'($urandom), 5'($urandom_range(1, 30)), 10'($urandom)};
    return v;
  endfunction

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    int          guard_cnt;

    rst      = 1'b1;
    in_valid = 1'b0;
    a        = 16'h0;
    b        = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    idle(2);

    // Basic product and latency
    issue(16'h4000, 16'h4200, 1'b1, 1'b0, 16'h4600);
    idle(5);

    // Back-to-back stream
    issue(16'h4000, 16'h4200, 1'b1, 1'b0, 16'h4600);
    issue(16'hC000, 16'h4200, 1'b1, 1'b0, 16'hC600);
    issue(16'h3E00, 16'h3E00, 1'b1, 1'b0, 16'h4080);
    issue(16'h3C01, 16'h3C01, 1'b1, 1'b0, 16'h3C02);
    idle(4);

    // Rounding tie, overflow/underflow, specials
    issue(16'h3C01, 16'h3E00, 1'b1, 1'b0, 16'h3E02);
    issue(16'h7BFF, 16'h4000, 1'b1, 1'b0, 16'h7C00);
    issue(16'h0400, 16'h3800, 1'b1, 1'b0, 16'h0000);
    issue(16'h8400, 16'h3800, 1'b1, 1'b0, 16'h8000);
    issue(16'h0001, 16'h7BFF, 1'b1, 1'b0, 16'h0000);
    issue(16'h7C00, 16'h0000, 1'b1, 1'b0, 16'h7E00);
    issue(16'h7E00, 16'h3C00, 1'b1, 1'b0, 16'h7E00);
    issue(16'hFC00, 16'h4000, 1'b1, 1'b0, 16'hFC00);
    issue(16'h8000, 16'h4200, 1'b1, 1'b0, 16'h8000);
    idle(4);

    // Bubble pattern 1,0,1; out must hold through the gap
    issue(16'h4200, 16'h4200, 1'b1, 1'b0, 16'h4880);
    issue(16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000);
    issue(16'h3800, 16'h4400, 1'b1, 1'b0, 16'h4000);
    idle(4);

    // Reset mid-operation: in-flight pairs and the same-edge pair are dropped
    issue(16'h4000, 16'h4200, 1'b1, 1'b0, 16'h4600);
    issue(16'h4400, 16'h4400, 1'b1, 1'b0, 16'h4C00);
    @(posedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b1;
    a        = 16'h3C00;
    b        = 16'h3C00;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    idle(5);

    // Randomized traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      ra = rand_operand();
      rb = rand_operand();
      issue(ra, rb, ($urandom_range(0, 9) < 8), 1'b1, 16'h0);
    end

    // Drain, bounded
    guard_cnt = 0;
    while (sb.size() > 0 && guard_cnt < 20) begin
      idle(1);
      guard_cnt++;
    end
    idle(2);
    if (sb.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results still pending, required 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
